// File: rtl/usb_dfu_flash_sequencer_if.sv
// Control and byte-stream interface between the DFU flash sequencer (master)
// and the SPI flash bridge (slave).
interface usb_dfu_flash_sequencer_if;
    logic [15:0] flash_address;
    logic        flash_rd_request;
    logic        flash_rd_data_free;
    logic        flash_rd_data_put;
    logic [7:0]  flash_rd_data;
    logic        flash_wr_request;
    logic        flash_wr_busy;
    logic        flash_wr_data_avail;
    logic        flash_wr_data_get;
    logic [7:0]  flash_wr_data;

    modport master (
        output flash_address, flash_rd_request, flash_rd_data_free,
               flash_wr_request, flash_wr_data_avail, flash_wr_data,
        input  flash_rd_data_put, flash_rd_data, flash_wr_busy, flash_wr_data_get
    );

    modport slave (
        input  flash_address, flash_rd_request, flash_rd_data_free,
               flash_wr_request, flash_wr_data_avail, flash_wr_data,
        output flash_rd_data_put, flash_rd_data, flash_wr_busy, flash_wr_data_get
    );
endinterface

// File: rtl/usb_dfu_flash_sequencer.sv
// Turns one DFU DNLOAD/UPLOAD block request into a single page program or streaming
// read on the SPI flash bridge, with partition range/length checks and completion status.
module usb_dfu_flash_sequencer #(
    parameter int unsigned PAGE_SIZE      = 256,
    parameter logic [15:0] PAGE_BASE      = 16'h0280,
    parameter logic [15:0] PAGE_LIMIT     = 16'h1000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dfu_dnload_start,
    input  logic        dfu_upload_start,
    input  logic [15:0] dfu_block,
    input  logic [15:0] dfu_length,
    output logic        dfu_busy,
    output logic        dfu_done,
    output logic [1:0]  dfu_status,
    input  logic        out_data_avail,
    output logic        out_data_get,
    input  logic [7:0]  out_data,
    input  logic        in_data_free,
    output logic        in_data_put,
    output logic [7:0]  in_data,
    usb_dfu_flash_sequencer_if.master flash
);
    localparam logic [16:0] PAGE_SIZE_W    = 17'(PAGE_SIZE);
    localparam logic [1:0]  STATUS_OK      = 2'd0;
    localparam logic [1:0]  STATUS_ADDR    = 2'd1;
    localparam logic [1:0]  STATUS_LEN     = 2'd2;
    localparam logic [1:0]  STATUS_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DN_STREAM = 3'd1,
        ST_DN_WAIT   = 3'd2,
        ST_UP_STREAM = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] remaining_r;
    logic [15:0] address_r;
    logic [23:0] timer_r;
    logic        seen_busy_r;
    logic [1:0]  status_r;
    logic [7:0]  wr_data_r;

    logic [16:0] page_sum_s;
    logic        addr_err_s;
    logic        len_err_s;
    logic        start_s;
    logic        rem_nz_s;
    logic        wr_get_s;
    logic        rd_put_s;
    logic        wait_ok_s;
    logic        timeout_s;
    logic [1:0]  start_status_s;

    // The 17th sum bit catches a block number that wraps the 16-bit page space.
    assign page_sum_s = {1'b0, PAGE_BASE} + {1'b0, dfu_block};
    assign addr_err_s = page_sum_s[16] || (page_sum_s[15:0] >= PAGE_LIMIT);
    assign len_err_s  = dfu_dnload_start && ({1'b0, dfu_length} > PAGE_SIZE_W);
    assign start_s    = dfu_dnload_start || dfu_upload_start;
    assign rem_nz_s   = (remaining_r != 16'd0);
    assign wr_get_s   = (state_r == ST_DN_STREAM) && rem_nz_s && flash.flash_wr_data_get;
    assign rd_put_s   = (state_r == ST_UP_STREAM) && rem_nz_s && flash.flash_rd_data_put;
    assign wait_ok_s  = seen_busy_r && !flash.flash_wr_busy;
    assign timeout_s  = (timer_r >= TIMEOUT_CYCLES);

    assign dfu_busy            = (state_r != ST_IDLE) || flash.flash_wr_busy;
    assign dfu_status          = status_r;
    assign flash.flash_address = address_r;
    assign flash.flash_wr_data = wr_data_r;

    // Status recorded when a request is accepted: address error outranks length error.
    always_comb begin
        start_status_s = STATUS_OK;
        if (addr_err_s) begin
            start_status_s = STATUS_ADDR;
        end else if (len_err_s) begin
            start_status_s = STATUS_LEN;
        end else begin
            start_status_s = STATUS_OK;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; download wins when both start pulses coincide.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!start_s) begin
                    state_s = ST_IDLE;
                end else if (addr_err_s || len_err_s || (dfu_length == 16'd0)) begin
                    state_s = ST_DONE;
                end else if (dfu_dnload_start) begin
                    state_s = ST_DN_STREAM;
                end else begin
                    state_s = ST_UP_STREAM;
                end
            end
            ST_DN_STREAM: begin
                if (rem_nz_s) state_s = ST_DN_STREAM;
                else          state_s = ST_DN_WAIT;
            end
            ST_DN_WAIT: begin
                if (wait_ok_s || timeout_s) state_s = ST_DONE;
                else                        state_s = ST_DN_WAIT;
            end
            ST_UP_STREAM: begin
                if (rem_nz_s) state_s = ST_UP_STREAM;
                else          state_s = ST_DONE;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: endpoint and bridge strobes decoded from state and byte count.
    always_comb begin
        dfu_done                  = 1'b0;
        out_data_get              = 1'b0;
        in_data_put               = 1'b0;
        in_data                   = 8'd0;
        flash.flash_rd_request    = 1'b0;
        flash.flash_rd_data_free  = 1'b0;
        flash.flash_wr_request    = 1'b0;
        flash.flash_wr_data_avail = 1'b0;
        case (state_r)
            ST_DN_STREAM: begin
                flash.flash_wr_request    = rem_nz_s;
                flash.flash_wr_data_avail = out_data_avail && rem_nz_s;
                out_data_get              = wr_get_s;
            end
            ST_UP_STREAM: begin
                flash.flash_rd_request   = rem_nz_s;
                flash.flash_rd_data_free = in_data_free && rem_nz_s;
                in_data_put              = rd_put_s;
                if (rd_put_s) in_data = flash.flash_rd_data;
                else          in_data = 8'd0;
            end
            ST_DONE: dfu_done = 1'b1;
            default: dfu_done = 1'b0;
        endcase
    end

    // Byte counter, program timer and bridge-busy observation.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_r <= 16'd0;
            timer_r     <= 24'd0;
            seen_busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        remaining_r <= dfu_length;
                        timer_r     <= 24'd0;
                        seen_busy_r <= 1'b0;
                    end
                end
                ST_DN_STREAM, ST_DN_WAIT: begin
                    if (!timeout_s) timer_r <= timer_r + 24'd1;
                    seen_busy_r <= seen_busy_r | flash.flash_wr_busy;
                    if (wr_get_s) remaining_r <= remaining_r - 16'd1;
                end
                ST_UP_STREAM: begin
                    if (rd_put_s) remaining_r <= remaining_r - 16'd1;
                end
                default: remaining_r <= remaining_r;
            endcase
        end
    end

    // Page address and completion status, both held until the next accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            address_r <= 16'd0;
            status_r  <= STATUS_OK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        address_r <= page_sum_s[15:0];
                        status_r  <= start_status_s;
                    end
                end
                ST_DN_WAIT: begin
                    if (wait_ok_s)      status_r <= STATUS_OK;
                    else if (timeout_s) status_r <= STATUS_TIMEOUT;
                end
                default: status_r <= status_r;
            endcase
        end
    end

    // Write byte is captured on the get so it is stable while the bridge caches it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_data_r <= 8'd0;
        end else if (wr_get_s) begin
            wr_data_r <= out_data;
        end
    end
endmodule
